// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery-domain blocks: p = 2^255 - 19, R = 2^255.
package mont_pkg;

    localparam int WIDTH = 255;
    localparam logic [WIDTH-1:0] P = {WIDTH{1'b1}} - WIDTH'(18);

    typedef enum logic {
        MODE_TO   = 1'b0,
        MODE_FROM = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mont_conv_step.sv
// One modular doubling (to-domain) or halving (from-domain) step on a reduced accumulator.
// The halving path exists only when MONT_CONV_FROM_EN is defined.
module mont_conv_step
    import mont_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  mode_t            mode,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   dbl;
    logic [WIDTH-1:0] dbl_sub;
    logic [WIDTH-1:0] dbl_res;

    // acc < P, so 2*acc < 2P and a single conditional subtract fully reduces it
    assign dbl     = {acc, 1'b0};
    assign dbl_sub = dbl[WIDTH-1:0] - P;
    assign dbl_res = (dbl >= {1'b0, P}) ? dbl_sub : dbl[WIDTH-1:0];

`ifdef MONT_CONV_FROM_EN
    // For odd acc, (acc + P) / 2 == (acc >> 1) + (P >> 1) + 1, which stays below P
    localparam logic [WIDTH-1:0] P_HALF_UP = (P >> 1) + WIDTH'(1);

    logic [WIDTH-1:0] half_res;

    assign half_res = acc[0] ? ({1'b0, acc[WIDTH-1:1]} + P_HALF_UP)
                             : {1'b0, acc[WIDTH-1:1]};
    assign acc_next = (mode == MODE_FROM) ? half_res : dbl_res;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign acc_next    = dbl_res;
`endif

endmodule

// File: rtl/mont_convert.sv
// Bit-serial converter into (x*R mod p) or out of (x*R^-1 mod p) the Montgomery domain.
// MONT_CONV_FROM_EN enables the from-domain mode; without it every request is to-domain.
module mont_convert
    import mont_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [7:0] LAST_STEP = 8'(WIDTH - 1);

    state_t           state;
    mode_t            mode;
    mode_t            mode_load;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] acc_load;

    // Inputs can reach 2^255 - 1 = P + 18, so one subtract reduces them
    assign acc_load = (in_data >= P) ? (in_data - P) : in_data;

`ifdef MONT_CONV_FROM_EN
    assign mode_load = mode_t'(in_mode);
`else
    logic unused_in_mode;

    assign unused_in_mode = in_mode;
    assign mode_load      = MODE_TO;
`endif

    mont_conv_step u_step (
        .acc      (acc),
        .mode     (mode),
        .acc_next (acc_next)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode      <= MODE_TO;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= acc_load;
                        mode  <= mode_load;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_convert.sv
// Testbench for mont_convert.
module tb_mont_convert;

    localparam logic [511:0] PW = (512'd1 << 255) - 512'd19;
    localparam logic [254:0] P255 = PW[254:0];

`ifdef MONT_CONV_FROM_EN
    localparam bit FROM_EN = 1'b1;
`else
    localparam bit FROM_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [254:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [254:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int prev_acc = 0;
    bit bp_mode = 1'b0;
    bit ready_level = 1'b1;
    logic [254:0] exp_q[$];

    mont_convert dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // R = 2^255 is congruent to 19 mod p, so entering is x*19 and leaving is x/19 (mod p)
    function automatic logic [254:0] model(input logic [254:0] x, input logic m);
        logic [511:0] v;
        logic [511:0] t;
        logic [511:0] res;
        bit found;
        v = {257'd0, x};
        while (v >= PW) v = v - PW;
        res = '0;
        found = 1'b0;
        if (m && FROM_EN) begin
            for (int k = 0; k < 19; k++) begin
                t = v + PW * 512'(k);
                if (!found && (t % 512'd19) == 512'd0) begin
                    res = t / 512'd19;
                    found = 1'b1;
                end
            end
        end
        if (!found) begin
            res = v * 512'd19;
            while (res >= PW) res = res - PW;
        end
        return res[254:0];
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[254:0];
    endfunction

    task automatic chk(input string name, input logic [254:0] got, input logic [254:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Scoreboard: expectations are pushed on acceptance and checked every cycle
    initial begin : monitor
        logic prev_valid;
        logic prev_hs;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                prev_valid = 1'b0;
                prev_hs = 1'b0;
                chk_bit("rst_out_valid", out_valid, 1'b0);
                chk_bit("rst_busy", busy, 1'b0);
                chk("rst_out_data", out_data, '0);
            end else begin
                chk_bit("ready_vs_busy", in_ready, !busy);
                if (prev_hs) begin
                    chk_bit("idle_after_take", in_ready, 1'b1);
                    chk_bit("valid_cleared", out_valid, 1'b0);
                end
                if (!out_valid) begin
                    chk("data_zero_when_invalid", out_data, '0);
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got out_valid=1 data %h expected no result", out_data);
                    end else begin
                        chk("result", out_data, exp_q[0]);
                    end
                    if (!prev_valid) chk_int("latency", cyc - last_acc, 255);
                end
                prev_hs = out_valid && out_ready;
                if (prev_hs && exp_q.size() > 0) void'(exp_q.pop_front());
                prev_valid = out_valid;
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_data, in_mode));
                    prev_acc = last_acc;
                    last_acc = cyc + 1;
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic send(input logic [254:0] x, input logic m);
        @(posedge clk);
        #1;
        in_data = x;
        in_mode = m;
        in_valid = 1'b1;
        wait_ready("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = rand255();
        in_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic collect(output logic [254:0] r);
        bit ok;
        ok = 1'b0;
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                r = out_data;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("collect");
    endtask

    task automatic run(input logic [254:0] x, input logic m, input string name, input logic [254:0] exp);
        logic [254:0] r;
        send(x, m);
        collect(r);
        chk(name, r, exp);
    endtask

    initial begin : main
        logic [254:0] x;
        logic [254:0] r;
        logic [254:0] y;
        logic [254:0] r1;
        logic [254:0] r2;
        bit ok;

        rst = 1'b0;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_bit("in_ready_after_reset", in_ready, 1'b1);
        chk_bit("busy_after_reset", busy, 1'b0);

        chk("model_to_1", model(255'd1, 1'b0), 255'h13);
        chk("model_to_pm1", model(P255 - 255'd1, 1'b0), P255 - 255'd19);
        chk("model_from_13", model(255'h13, 1'b1), FROM_EN ? 255'd1 : 255'h169);

        run(255'd1, 1'b0, "to_1", 255'h13);
        run(255'd2, 1'b0, "to_2", 255'h26);
        run(255'd0, 1'b0, "to_0", 255'd0);
        run(P255, 1'b0, "to_p", 255'd0);
        run({255{1'b1}}, 1'b0, "to_max", 255'h156);
        run(P255 - 255'd1, 1'b0, "to_pm1", P255 - 255'd19);
        run(255'h13, 1'b1, "from_13", FROM_EN ? 255'd1 : 255'h169);
        run(255'd0, 1'b1, "from_0", 255'd0);

        for (int i = 0; i < 3; i++) begin
            x = rand255();
            if (x >= P255) x = x - P255;
            send(x, 1'b0);
            collect(r);
            send(r, 1'b1);
            collect(y);
            chk("round_trip", y, FROM_EN ? x : model(r, 1'b1));
        end

        // Backpressure in DONE, with stray in_valid pulses that must be ignored
        ready_level = 1'b0;
        send(255'd2, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("bp_wait_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 3 || i == 4);
            in_data = rand255();
            @(negedge clk);
            chk("bp_data_stable", out_data, 255'h26);
            chk_bit("bp_valid_held", out_valid, 1'b1);
            chk_bit("bp_in_ready_low", in_ready, 1'b0);
        end
        ready_level = 1'b1;
        @(negedge clk);
        chk_bit("bp_valid_until_taken", out_valid, 1'b1);
        @(negedge clk);
        chk_bit("bp_idle_next", in_ready, 1'b1);

        // Reset in the middle of a run
        send(255'd7, 1'b0);
        repeat (100) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_bit("abort_out_valid", out_valid, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        chk("abort_out_data", out_data, '0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_bit("abort_in_ready", in_ready, 1'b1);
        run(255'd1, 1'b0, "after_abort", 255'h13);

        // Randomized operands, modes and consumer backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0)
                x = P255 + 255'($urandom_range(0, 18));
            else if ($urandom_range(0, 3) == 0)
                x = P255 - 255'($urandom_range(1, 40));
            else
                x = rand255();
            send(x, 1'($urandom_range(0, 1)));
            collect(r);
        end
        bp_mode = 1'b0;
        ready_level = 1'b1;

        // Back-to-back with in_valid held high
        @(posedge clk);
        #1;
        in_data = 255'd1;
        in_mode = 1'b0;
        in_valid = 1'b1;
        wait_ready("b2b_first");
        @(posedge clk);
        #1;
        in_data = 255'd2;
        collect(r1);
        wait_ready("b2b_second");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(r2);
        chk("b2b_first", r1, 255'h13);
        chk("b2b_second", r2, 255'h26);
        chk_int("b2b_spacing", last_acc - prev_acc, 257);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
